sdp_mrdma_ig_cmd: RTL

- Ingress command generator of the SDP memory read DMA, directly upstream of the MRDMA egress stage.
- On op_load it walks a 2-D surface of `height+1` lines, each `width+1` 32-byte atoms.
- Each line is split into DMA read requests of at most MAX_BURST atoms.
- For every request issued to the DMA it pushes one matching 14-bit command-queue entry, which the egress stage later consumes as cq2eg_pd.

---
 rtl/sdp_mrdma_pkg.sv | 44 ++++
 rtl/sdp_mrdma_ig_cmd.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sdp_mrdma_pkg.sv
// sdp_mrdma_pkg
//   Definitions shared by the SDP memory-read DMA stages. The ingress
//   command generator packs command-queue entries and DMA request sizes
//   with the helpers below, and the egress stage decodes them with the
//   same helpers, so both sides always agree on the bit layout.
//   Command-queue entry : {cube_end[13], size[12:0] = atoms-1}
//   DMA request size    : 15-bit atoms-1, upper bits always zero
package sdp_mrdma_pkg;

  localparam int ATOM_BYTES        = 32;
  localparam int ATOM_SHIFT        = 5;   // log2(ATOM_BYTES)
  localparam int CQ_PD_W           = 14;
  localparam int CQ_SIZE_LSB       = 0;
  localparam int CQ_SIZE_W         = 13;
  localparam int CQ_CUBE_END_BIT   = 13;
  localparam int DMA_RD_REQ_SIZE_W = 15;

  typedef enum logic {
    IG_IDLE = 1'b0,
    IG_RUN  = 1'b1
  } ig_state_e;

  function automatic logic [CQ_PD_W-1:0] pack_cq_pd(input logic                 cube_end,
                                                    input logic [CQ_SIZE_W-1:0] size);
    logic [CQ_PD_W-1:0] pd;
    pd                                = '0;
    pd[CQ_SIZE_LSB +: CQ_SIZE_W]      = size;
    pd[CQ_CUBE_END_BIT]               = cube_end;
    return pd;
  endfunction

  function automatic logic [CQ_SIZE_W-1:0] cq_pd_size(input logic [CQ_PD_W-1:0] pd);
    return pd[CQ_SIZE_LSB +: CQ_SIZE_W];
  endfunction

  function automatic logic cq_pd_cube_end(input logic [CQ_PD_W-1:0] pd);
    return pd[CQ_CUBE_END_BIT];
  endfunction

  function automatic logic [DMA_RD_REQ_SIZE_W-1:0] dma_req_size(input logic [CQ_SIZE_W-1:0] size);
    return {{(DMA_RD_REQ_SIZE_W-CQ_SIZE_W){1'b0}}, size};
  endfunction

endpackage

// File: rtl/sdp_mrdma_ig_cmd.sv
// sdp_mrdma_ig_cmd
//   Ingress command generator of the SDP memory-read DMA. A start pulse
//   captures the surface description; the block then walks height+1 lines
//   of width+1 32-byte atoms, splitting each line into DMA read requests
//   of at most MAX_BURST atoms. Every DMA request is issued together with
//   one command-queue entry for the egress stage (paired handshake).
// Ports
//   nvdla_core_clk / nvdla_core_rst : clock, asynchronous active-high reset
//   op_load                         : start pulse (ignored while running)
//   ig_done                         : one-cycle pulse after the final pair
//   reg2dp_*                        : surface base, line stride, width-1, height-1
//   dma_rd_req_vld/rdy/pd           : DMA read request {size-1, byte addr}
//   cq_wr_pvld/prdy/pd              : command-queue write {cube_end, size-1}
//   dp2reg_mrdma_stall              : saturating count of non-accept RUN cycles
module sdp_mrdma_ig_cmd
  import sdp_mrdma_pkg::*;
#(
  parameter int MAX_BURST = 256,
  parameter int ADDR_W    = 64
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  input  logic                           op_load,
  output logic                           ig_done,
  input  logic [ADDR_W-1:0]              reg2dp_base_addr,
  input  logic [31:0]                    reg2dp_line_stride,
  input  logic [12:0]                    reg2dp_width,
  input  logic [12:0]                    reg2dp_height,
  output logic                           dma_rd_req_vld,
  input  logic                           dma_rd_req_rdy,
  output logic [ADDR_W+DMA_RD_REQ_SIZE_W-1:0] dma_rd_req_pd,
  output logic                           cq_wr_pvld,
  input  logic                           cq_wr_prdy,
  output logic [CQ_PD_W-1:0]             cq_wr_pd,
  output logic [31:0]                    dp2reg_mrdma_stall
);

  // 14 bits so that width+1 = 8192 is representable
  localparam logic [13:0] BURST14 = 14'(MAX_BURST);
  localparam logic [12:0] BURST13 = 13'(MAX_BURST);

  ig_state_e         r_state;
  ig_state_e         w_state_next;
  logic [12:0]       r_width;
  logic [12:0]       r_height;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_line_base;
  logic [12:0]       r_atom_off;
  logic [12:0]       r_line_cnt;
  logic              r_done;
  logic              w_done_next;
  logic [31:0]       r_stall;

  logic              w_run;
  logic              w_accept;
  logic              w_start;
  logic [13:0]       w_rem;
  logic [13:0]       w_n;
  logic              w_last_in_line;
  logic              w_cube_end;
  logic [12:0]       w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_base_aln;
  logic [ADDR_W-1:0] w_stride_aln;

  // Low five address bits are ignored: surfaces and strides are atom aligned
  assign w_base_aln   = reg2dp_base_addr & ~ADDR_W'(ATOM_BYTES - 1);
  assign w_stride_aln = ADDR_W'(reg2dp_line_stride & 32'hFFFF_FFE0);

  assign w_run    = (r_state == IG_RUN);
  assign w_accept = w_run && dma_rd_req_rdy && cq_wr_prdy;
  assign w_start  = (r_state == IG_IDLE) && op_load;

  // Current request, derived purely from the walk position
  assign w_rem          = {1'b0, r_width} + 14'd1 - {1'b0, r_atom_off};
  assign w_last_in_line = (w_rem <= BURST14);
  assign w_n            = w_last_in_line ? w_rem : BURST14;
  assign w_size         = 13'(w_n - 14'd1);
  assign w_cube_end     = w_last_in_line && (r_line_cnt == r_height);
  assign w_addr         = r_line_base + ADDR_W'({r_atom_off, 5'b0});

  // Each valid waits on the opposite ready so neither side can take a
  // transfer the other has not also agreed to take in the same cycle.
  assign dma_rd_req_vld     = w_run && cq_wr_prdy;
  assign cq_wr_pvld         = w_run && dma_rd_req_rdy;
  assign dma_rd_req_pd      = w_run ? {dma_req_size(w_size), w_addr} : '0;
  assign cq_wr_pd           = w_run ? pack_cq_pd(w_cube_end, w_size) : '0;
  assign ig_done            = r_done;
  assign dp2reg_mrdma_stall = r_stall;

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    unique case (r_state)
      IG_IDLE: begin
        if (op_load) w_state_next = IG_RUN;
      end
      IG_RUN: begin
        if (w_accept && w_cube_end) begin
          w_state_next = IG_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IG_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_state <= IG_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_width     <= '0;
      r_height    <= '0;
      r_stride    <= '0;
      r_line_base <= '0;
      r_atom_off  <= '0;
      r_line_cnt  <= '0;
    end else if (w_start) begin
      r_width     <= reg2dp_width;
      r_height    <= reg2dp_height;
      r_stride    <= w_stride_aln;
      r_line_base <= w_base_aln;
      r_atom_off  <= '0;
      r_line_cnt  <= '0;
    end else if (w_accept) begin
      if (!w_last_in_line) begin
        r_atom_off <= r_atom_off + BURST13;
      end else if (!w_cube_end) begin
        r_atom_off  <= '0;
        r_line_cnt  <= r_line_cnt + 13'd1;
        r_line_base <= r_line_base + r_stride;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_stall <= '0;
    end else if (w_start) begin
      r_stall <= '0;
    end else if (w_run && !w_accept && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

endmodule
